rv32i_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It owns the instruction life cycle (fetch, decode, execute, memory, write-back), drives every datapath enable and mux select around the decoder, ALU, register file and PC, and arbitrates the single shared memory port between instruction fetch and load/store traffic through a req/ready handshake. It also reports halt and trap status and keeps a retired-instruction counter.

---
 rtl/rv32i_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl
//   Multi-cycle control sequencer for the RV32I core. Walks each instruction
//   through FETCH, DECODE, EXEC, MEM and WB. It drives the datapath enables and
//   mux selects, and shares the single memory port between instruction fetch
//   and load/store using a req/ready handshake. Illegal opcodes and memory
//   timeouts end in a sticky TRAP. ECALL ends in a sticky HALT. A 32-bit
//   counter tracks retired instructions.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start                     leave IDLE and begin fetching
//   opcode, funct3            instruction fields held stable by IR
//   branch_taken              branch-compare result, sampled in EXEC
//   mem_ready                 memory accepted/completed the current request
//   mem_req, mem_we           memory request / store strobe
//   mem_addr_sel              0 = PC, 1 = ALU result
//   ir_we, pc_we, pc_src      IR load, PC update and PC source
//   alu_a_sel, alu_b_sel      ALU operand selects
//   rf_we, wb_sel             register-file write and write-back source
//   busy, halted, trap        status flags
//   trap_cause                0 none, 1 illegal opcode, 2 bus timeout
//   instret                   retired-instruction count
module rv32i_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        busy,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE,
    C_OPIMM, C_OP, C_SYS, C_ILL
  } cls_t;

  // The counter has already seen MEM_TIMEOUT-1 unanswered request cycles.
  // One more such cycle traps.
  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  cause_q, cause_d;
  logic        retire;

  function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
    cls_t c;
    case (op)
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b1100011: c = C_BRANCH;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b0010011: c = C_OPIMM;
      7'b0110011: c = C_OP;
      7'b1110011: c = (f3 == 3'b000) ? C_SYS : C_ILL;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ILL;
      tmo_q     <= '0;
      instret_q <= '0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    tmo_d        = tmo_q;
    cause_d      = cause_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;
    trap         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_DECODE: begin
        cls_d = classify(opcode, funct3);
        if (cls_d == C_SYS) begin
          state_d = S_HALT;
        end else if (cls_d == C_ILL) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cls_q)
          C_OPIMM, C_LOAD, C_STORE, C_JALR: alu_b_sel = 1'b1;
          C_LUI: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 1'b1;
          end
          C_AUIPC: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
          end
          default: ;
        endcase
        if (cls_q == C_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = {1'b0, branch_taken};
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        wb_sel = (cls_q == C_LOAD) ? 2'd1 :
                 (cls_q == C_JAL || cls_q == C_JALR) ? 2'd2 : 2'd0;
        pc_src = (cls_q == C_JAL) ? 2'd1 : (cls_q == C_JALR) ? 2'd2 : 2'd0;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_TRAP: trap = 1'b1;

      default: state_d = S_IDLE;
    endcase

    // Every state change starts a fresh wait budget. This covers entry
    // into FETCH and MEM, including the back-to-back STORE MEM->FETCH case.
    if (state_d != state_q) tmo_d = '0;

    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_MEM) ||
                      (state_q == S_WB);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
module tb_rv32i_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, branch_taken, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  logic [1:0]  pc_src, alu_a_sel, wb_sel, trap_cause;
  logic        alu_b_sel, busy, halted, trap;
  logic [31:0] instret;
  logic [15:0] obs;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .busy(busy), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_a_sel,
                alu_b_sel, rf_we, wb_sel, busy, halted, trap};

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
    OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BR = 7'b1100011,
    OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_IMM = 7'b0010011,
    OP_OP = 7'b0110011, OP_SYS = 7'b1110011;

  int total = 0;
  int bad = 0;
  int unsigned exp_instret = 0;

  typedef struct { logic [15:0] o; bit rdy; bit bt; } cyc_t;
  cyc_t plan_q[$];

  typedef struct {
    logic [6:0] op; logic [2:0] f3; bit tk; int wf; int wm; int cycles;
  } vec_t;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] pk(bit rq, bit we, bit as, bit iw, bit pw,
      logic [1:0] ps, logic [1:0] a, bit b, bit rw, logic [1:0] ws,
      bit bs, bit h, bit t);
    return {rq, we, as, iw, pw, ps, a, b, rw, ws, bs, h, t};
  endfunction

  function automatic void push(logic [15:0] o, bit rdy, bit bt);
    cyc_t c;
    c.o = o; c.rdy = rdy; c.bt = bt;
    plan_q.push_back(c);
  endfunction

  localparam logic [15:0] O_BUSY = 16'h0004, O_HALT = 16'h0002,
                          O_TRAP = 16'h0001;

  // Expected per-cycle outputs of one instruction, starting at its first
  // FETCH cycle, built from the instruction's phase list.
  function automatic void plan(logic [6:0] op, logic [2:0] f3, bit tk,
                               int wf, int wm);
    bit ld, st, br, jal, jalr, legal, b;
    logic [1:0] a, ps, ws;
    ld = (op == OP_LD); st = (op == OP_ST); br = (op == OP_BR);
    jal = (op == OP_JAL); jalr = (op == OP_JALR);
    legal = ld | st | br | jal | jalr | (op == OP_LUI) | (op == OP_AUIPC) |
            (op == OP_IMM) | (op == OP_OP);
    plan_q.delete();
    for (int i = 0; i < wf; i++) push(pk(1,0,0,0,0,0,0,0,0,0,1,0,0), 0, rb());
    push(pk(1,0,0,1,0,0,0,0,0,0,1,0,0), 1, rb());
    push(O_BUSY, rb(), rb());
    if (op == OP_SYS && f3 == 3'd0) begin
      push(O_HALT, rb(), rb());
      return;
    end
    if (!legal) begin
      push(O_TRAP, rb(), rb());
      return;
    end
    a = 2'd0; b = 1'b0;
    if (op == OP_IMM || ld || st || jalr) b = 1'b1;
    else if (op == OP_LUI) begin a = 2'd2; b = 1'b1; end
    else if (op == OP_AUIPC) begin a = 2'd1; b = 1'b1; end
    push(pk(0,0,0,0,br, br ? {1'b0, tk} : 2'd0, a, b, 0, 0, 1, 0, 0),
         rb(), br ? tk : rb());
    if (br) return;
    if (ld || st) begin
      for (int i = 0; i < wm; i++) push(pk(1,st,1,0,0,0,0,0,0,0,1,0,0), 0, rb());
      push(pk(1,st,1,0,st,0,0,0,0,0,1,0,0), 1, rb());
      if (st) return;
    end
    ws = ld ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0;
    ps = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
    push(pk(0,0,0,0,1,ps,0,0,1,ws,1,0,0), rb(), rb());
  endfunction

  // Entered and left just after a rising edge.
  task automatic play(input string nm, output int ret);
    logic [31:0] base;
    base = instret;
    ret = 0;
    for (int i = 0; i < plan_q.size(); i++) begin
      mem_ready = plan_q[i].rdy;
      branch_taken = plan_q[i].bt;
      @(negedge clk);
      check($sformatf("%s_c%0d", nm, i), {16'h0, obs}, {16'h0, plan_q[i].o});
      @(posedge clk); #1;
      if (ret == 0 && instret !== base) ret = i + 1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    check("idle_before_start", {16'h0, obs}, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    check({nm, "_outs"}, {16'h0, obs}, 32'h0);
    check({nm, "_instret"}, instret, 32'h0);
    check({nm, "_cause"}, {30'h0, trap_cause}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = 0;
  endtask

  task automatic start_ignored(input string nm, input logic [15:0] pat);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rb();
      @(negedge clk);
      check($sformatf("%s_sticky%0d", nm, i), {16'h0, obs}, {16'h0, pat});
      @(posedge clk); #1;
    end
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  vec_t tbl[12];
  logic [6:0] legal_ops[9];

  initial begin
    int ret;
    tbl[0]  = '{OP_IMM,   3'd0, 1'b0, 0, 0, 4};   // ADDI
    tbl[1]  = '{OP_LD,    3'd2, 1'b0, 2, 3, 10};  // LW, slow fetch and MEM
    tbl[2]  = '{OP_BR,    3'd0, 1'b1, 0, 0, 3};   // BEQ taken
    tbl[3]  = '{OP_BR,    3'd0, 1'b0, 0, 0, 3};   // BEQ not taken
    tbl[4]  = '{OP_JALR,  3'd0, 1'b0, 0, 0, 4};
    tbl[5]  = '{OP_ST,    3'd2, 1'b0, 0, 0, 4};
    tbl[6]  = '{OP_LUI,   3'd5, 1'b0, 1, 0, 5};
    tbl[7]  = '{OP_JAL,   3'd0, 1'b0, 0, 0, 4};
    tbl[8]  = '{OP_AUIPC, 3'd1, 1'b0, 3, 0, 7};
    tbl[9]  = '{OP_OP,    3'd0, 1'b1, 0, 0, 4};
    tbl[10] = '{OP_LD,    3'd0, 1'b0, 0, 0, 5};
    tbl[11] = '{OP_ST,    3'd0, 1'b0, 1, 2, 7};
    legal_ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST,
                  OP_IMM, OP_OP};

    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    opcode = 7'h0; funct3 = 3'h0;
    #2;
    check("reset_outs", {16'h0, obs}, 32'h0);
    check("reset_instret", instret, 32'h0);
    check("reset_cause", {30'h0, trap_cause}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("idle_no_start", {16'h0, obs}, 32'h0);
    @(posedge clk); #1;
    mem_ready = 1'b0;

    do_start();
    for (int v = 0; v < 12; v++) begin
      opcode = tbl[v].op; funct3 = tbl[v].f3;
      plan(tbl[v].op, tbl[v].f3, tbl[v].tk, tbl[v].wf, tbl[v].wm);
      play($sformatf("vec%0d", v), ret);
      check($sformatf("vec%0d_latency", v), ret, tbl[v].cycles);
      exp_instret++;
      check($sformatf("vec%0d_instret", v), instret, exp_instret);
    end

    for (int r = 0; r < 60; r++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = legal_ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      opcode = op; funct3 = f3;
      plan(op, f3, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      play($sformatf("rnd%0d", r), ret);
      exp_instret++;
      check($sformatf("rnd%0d_instret", r), instret, exp_instret);
    end

    // Illegal opcode: sticky TRAP, count untouched, start ignored.
    opcode = 7'h7F; funct3 = 3'd0;
    plan(7'h7F, 3'd0, 1'b0, 0, 0);
    play("illegal", ret);
    check("illegal_cause", {30'h0, trap_cause}, 32'd1);
    check("illegal_instret", instret, exp_instret);
    start_ignored("illegal", O_TRAP);

    do_reset("rst1");
    do_start();
    opcode = OP_SYS; funct3 = 3'd0;
    plan(OP_SYS, 3'd0, 1'b0, 1, 0);
    play("ecall", ret);
    check("ecall_cause", {30'h0, trap_cause}, 32'd0);
    check("ecall_instret", instret, 32'd0);
    start_ignored("ecall", O_HALT);

    do_reset("rst2");
    do_start();
    opcode = OP_SYS; funct3 = 3'd1;
    plan(OP_SYS, 3'd1, 1'b0, 0, 0);
    play("sys_f3", ret);
    check("sys_f3_cause", {30'h0, trap_cause}, 32'd1);

    // Fetch never answered: four request cycles, then TRAP cause 2.
    do_reset("rst3");
    do_start();
    plan_q.delete();
    for (int i = 0; i < 4; i++) push(pk(1,0,0,0,0,0,0,0,0,0,1,0,0), 0, 1'b0);
    push(O_TRAP, 1'b1, 1'b0);
    play("fetch_tmo", ret);
    check("fetch_tmo_cause", {30'h0, trap_cause}, 32'd2);
    start_ignored("fetch_tmo", O_TRAP);

    // Ready on the limit cycle wins.
    do_reset("rst4");
    do_start();
    opcode = OP_IMM; funct3 = 3'd0;
    plan(OP_IMM, 3'd0, 1'b0, 3, 0);
    play("fetch_edge", ret);
    check("fetch_edge_latency", ret, 32'd7);
    check("fetch_edge_cause", {30'h0, trap_cause}, 32'd0);

    // Load whose data phase never completes.
    do_reset("rst5");
    do_start();
    opcode = OP_LD; funct3 = 3'd2;
    plan_q.delete();
    push(pk(1,0,0,1,0,0,0,0,0,0,1,0,0), 1, 1'b0);
    push(O_BUSY, 1'b0, 1'b0);
    push(pk(0,0,0,0,0,0,0,1,0,0,1,0,0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(pk(1,0,1,0,0,0,0,0,0,0,1,0,0), 0, 1'b0);
    push(O_TRAP, 1'b1, 1'b0);
    play("mem_tmo", ret);
    check("mem_tmo_cause", {30'h0, trap_cause}, 32'd2);
    check("mem_tmo_instret", instret, 32'd0);

    // Reset mid-MEM drops the request immediately.
    do_reset("rst6");
    do_start();
    opcode = OP_ST; funct3 = 3'd2;
    plan_q.delete();
    push(pk(1,0,0,1,0,0,0,0,0,0,1,0,0), 1, 1'b0);
    push(O_BUSY, 1'b0, 1'b0);
    push(pk(0,0,0,0,0,0,0,1,0,0,1,0,0), 1'b0, 1'b0);
    push(pk(1,1,1,0,0,0,0,0,0,0,1,0,0), 1'b0, 1'b0);
    play("mid_mem", ret);
    mem_ready = 1'b0;
    #2;
    check("mid_mem_req_before", {31'h0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_mem_async_outs", {16'h0, obs}, 32'h0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_mem_held_outs", {16'h0, obs}, 32'h0);
    check("mid_mem_instret", instret, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_mem_idle", {16'h0, obs}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
